alu_issue_decoder: RTL and testbench

Producer side of the ALU operand/control interface: accepts one fetched RISC-V RV32I instruction per handshake together with its PC and register-file read data. It decodes the instruction into the 4-bit `ALU_control` encoding plus the `inA`/`inB` operands that the ALU consumes. It registers the result into a valid/ready pipeline stage with a one-entry skid buffer, sitting between register read and the ALU/execute stage.

---
 rtl/alu_issue_decoder_if.sv | 41 ++++
 rtl/alu_issue_decoder.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue_decoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_decoder_if.sv
// Handshake bundle between register read and the ALU issue decoder.
// master drives the instruction side and out_ready; slave is the decoder.
interface alu_issue_decoder_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic [31:0]  in_pc;
  logic [31:0]  in_rs1_data;
  logic [31:0]  in_rs2_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_inA;
  logic [W-1:0] out_inB;
  logic [3:0]   out_ALU_control;
  logic         out_branch;
  logic [2:0]   out_funct3;
  logic [4:0]   out_rd;
  logic         out_illegal;

  modport master (
    output in_valid, in_instr, in_pc,
    output in_rs1_data, in_rs2_data,
    output out_ready,
    input  in_ready, out_valid,
    input  out_inA, out_inB,
    input  out_ALU_control, out_branch,
    input  out_funct3, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  in_rs1_data, in_rs2_data,
    input  out_ready,
    output in_ready, out_valid,
    output out_inA, out_inB,
    output out_ALU_control, out_branch,
    output out_funct3, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue_decoder.sv
// RV32I to ALU decode stage with output register and one-entry skid.
// Define ALU_ISSUE_ILLEGAL_EN to flag unsupported encodings.
module alu_issue_decoder #(
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               reset,
  alu_issue_decoder_if.slave bus
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   code;
    logic         branch;
    logic [2:0]   f3;
    logic [4:0]   rd;
    logic         ill;
  } op_t;

  function automatic logic [3:0] alu_code(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] c;
    case (f3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLT;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_alt;
  logic        is_shift;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] u_imm;

  assign instr    = bus.in_instr;
  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[31:25];
  assign f7_alt   = (f7 == 7'b0100000);
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign i_imm    = {{20{instr[31]}}, instr[31:20]};
  assign s_imm    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm    = {instr[31:12], 12'b0};

  logic is_op, is_imm, is_load, is_store;
  logic is_br, is_lui, is_auipc;

  assign is_op    = (opc == 7'b0110011);
  assign is_imm   = (opc == 7'b0010011);
  assign is_load  = (opc == 7'b0000011);
  assign is_store = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic f7_zero;
  logic op_ill;
  logic sh_ill;
  logic known;
  logic illegal;

  assign f7_zero = (f7 == 7'b0000000);
  assign op_ill  = !(f7_zero || (f7_alt &&
                   (f3 == 3'b000 || f3 == 3'b101)));
  assign sh_ill  = ((f3 == 3'b001) && !f7_zero) ||
                   ((f3 == 3'b101) && !f7_zero && !f7_alt);
  assign known   = is_op || is_imm || is_load || is_store ||
                   is_br || is_lui || is_auipc;
  assign illegal = !known ||
                   (is_op && op_ill) ||
                   (is_imm && sh_ill);
`endif

  op_t dec;

  always_comb begin
    dec    = '0;
    dec.f3 = f3;
    dec.rd = instr[11:7];
    unique case (1'b1)
      is_op: begin
        dec.a    = bus.in_rs1_data;
        dec.b    = bus.in_rs2_data;
        dec.code = alu_code(f3, f7_alt);
      end
      is_imm: begin
        dec.a    = bus.in_rs1_data;
        dec.b    = is_shift ? {27'b0, instr[24:20]} : i_imm;
        // funct7 bits are immediate for non-shift ops
        dec.code = alu_code(f3, f7_alt && (f3 == 3'b101));
      end
      is_load: begin
        dec.a = bus.in_rs1_data;
        dec.b = i_imm;
      end
      is_store: begin
        dec.a = bus.in_rs1_data;
        dec.b = s_imm;
      end
      is_br: begin
        dec.a      = bus.in_rs1_data;
        dec.b      = bus.in_rs2_data;
        dec.branch = 1'b1;
        dec.code   = f3[2] && f3[1] ? ALU_SLT : ALU_SUB;
      end
      is_lui: begin
        dec.b = u_imm;
      end
      is_auipc: begin
        dec.a = bus.in_pc;
        dec.b = u_imm;
      end
      default: ;
    endcase
`ifdef ALU_ISSUE_ILLEGAL_EN
    if (illegal) begin
      dec.a      = '0;
      dec.b      = '0;
      dec.code   = ALU_ADD;
      dec.branch = 1'b0;
      dec.ill    = 1'b1;
    end
`endif
  end

  op_t  out_q;
  op_t  skid_q;
  logic out_valid;
  logic skid_valid;
  logic acc;
  logic xfer;

  assign bus.in_ready = !skid_valid && !reset;
  assign acc  = bus.in_valid && bus.in_ready;
  assign xfer = out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || xfer) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= acc;
        if (acc) skid_q <= dec;
      end else begin
        out_valid <= acc;
        if (acc) out_q <= dec;
      end
    end else if (acc) begin
      // output stalled: park the in-flight op
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign bus.out_valid       = out_valid;
  assign bus.out_inA         = out_q.a;
  assign bus.out_inB         = out_q.b;
  assign bus.out_ALU_control = out_q.code;
  assign bus.out_branch      = out_q.branch;
  assign bus.out_funct3      = out_q.f3;
  assign bus.out_rd          = out_q.rd;
  assign bus.out_illegal     = out_q.ill;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Bench for alu_issue_decoder: vector table, handshake sequences,
// and random stream against a spec-level reference model.
module tb_alu_issue_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_decoder_if #(.W(32)) bus ();

  alu_issue_decoder #(.W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef ALU_ISSUE_ILLEGAL_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif

  // funct3 -> ALU code with funct7 = 0000000
  localparam logic [3:0] F3CODE [8] = '{
    4'b0000, 4'b0011, 4'b1000, 4'b1000,
    4'b0111, 4'b0101, 4'b0100, 4'b0010
  };

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  code;
    logic        br;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  int   n_chk = 0;
  int   n_pass = 0;
  logic last_rdy;
  exp_t q[$];
  vec_t vecs[19];

  function automatic exp_t got();
    exp_t g;
    g.a    = bus.out_inA;
    g.b    = bus.out_inB;
    g.code = bus.out_ALU_control;
    g.br   = bus.out_branch;
    g.f3   = bus.out_funct3;
    g.rd   = bus.out_rd;
    g.ill  = bus.out_illegal;
    return g;
  endfunction

  task automatic check(input string name, input exp_t g,
                       input exp_t e);
    n_chk++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got a=%h b=%h c=%b br=%b f3=%0d rd=%0d il=%b, want a=%h b=%h c=%b br=%b f3=%0d rd=%0d il=%b",
                  name, g.a, g.b, g.code, g.br, g.f3, g.rd, g.ill,
                  e.a, e.b, e.code, e.br, e.f3, e.rd, e.ill);
  endtask

  task automatic check_bit(input string name, input logic g,
                           input logic e);
    n_chk++;
    if (g === e) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, g, e);
  endtask

  function automatic logic [31:0] enc(
    input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic vec_t mk(
    input logic [31:0] ins, input logic [31:0] pc,
    input logic [31:0] r1, input logic [31:0] r2,
    input logic [31:0] ea, input logic [31:0] eb,
    input logic [3:0] ec, input logic ebr, input logic eil);
    vec_t v;
    v.instr  = ins;
    v.pc     = pc;
    v.rs1    = r1;
    v.rs2    = r2;
    v.e.a    = ea;
    v.e.b    = eb;
    v.e.code = ec;
    v.e.br   = ebr;
    v.e.f3   = ins[14:12];
    v.e.rd   = ins[11:7];
    v.e.ill  = eil;
    return v;
  endfunction

  // Reference decode written from the instruction-set rules
  function automatic exp_t model(
    input logic [31:0] i, input logic [31:0] pc,
    input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic        legal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alt;
    logic        shift;
    logic [11:0] imm12;
    logic [11:0] simm;
    e     = '0;
    legal = 1'b1;
    f3    = i[14:12];
    f7    = i[31:25];
    alt   = (f7 == 7'h20);
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    imm12 = i[31:20];
    simm  = {i[31:25], i[11:7]};
    e.f3  = f3;
    e.rd  = i[11:7];
    case (i[6:0])
      7'h33: begin
        e.a = r1;
        e.b = r2;
        e.code = F3CODE[f3];
        if (alt && f3 == 3'd0) e.code = 4'b0001;
        if (alt && f3 == 3'd5) e.code = 4'b0110;
        legal = (f7 == 7'h00) ||
                (alt && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h13: begin
        e.a = r1;
        e.b = shift ? {27'b0, i[24:20]}
                    : {{20{imm12[11]}}, imm12};
        e.code = F3CODE[f3];
        if (alt && f3 == 3'd5) e.code = 4'b0110;
        legal = !shift || (f7 == 7'h00) || (alt && f3 == 3'd5);
      end
      7'h03: begin
        e.a = r1;
        e.b = {{20{imm12[11]}}, imm12};
      end
      7'h23: begin
        e.a = r1;
        e.b = {{20{simm[11]}}, simm};
      end
      7'h63: begin
        e.a = r1;
        e.b = r2;
        e.br = 1'b1;
        e.code = (f3 == 3'd6 || f3 == 3'd7) ? 4'b1000 : 4'b0001;
      end
      7'h37: e.b = {i[31:12], 12'b0};
      7'h17: begin
        e.a = pc;
        e.b = {i[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    if (ILL && !legal) begin
      e.a    = '0;
      e.b    = '0;
      e.code = '0;
      e.br   = 1'b0;
      e.ill  = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  ops [7];
    int          sel;
    int          r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17};
    ins = $urandom;
    sel = $urandom_range(0, 8);
    if (sel < 7) ins[6:0] = ops[sel];
    r = $urandom_range(0, 3);
    if (r == 0 || r == 2) ins[31:25] = 7'h00;
    if (r == 1) ins[31:25] = 7'h20;
    return ins;
  endfunction

  // One cycle: drive at negedge, observe handshake, score transfers
  task automatic step(input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] r1,
                      input logic [31:0] r2, input logic ordy);
    exp_t e;
    @(negedge clk);
    bus.in_valid    = v;
    bus.in_instr    = ins;
    bus.in_pc       = pc;
    bus.in_rs1_data = r1;
    bus.in_rs2_data = r2;
    bus.out_ready   = ordy;
    #1;
    last_rdy = bus.in_ready;
    if (bus.out_valid && ordy) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL stream: got unexpected op rd=%0d, want none",
                 bus.out_rd);
      end else begin
        e = q.pop_front();
        check("stream", got(), e);
      end
    end
    if (v && bus.in_ready) q.push_back(model(ins, pc, r1, r2));
  endtask

  initial begin
    logic        pv;
    logic [31:0] pi, ppc, pa, pb;

    vecs[0]  = mk(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 0, 5, 7,
                  5, 7, 4'b0000, 0, 0);
    vecs[1]  = mk(enc(7'h20, 5'd4, 5'd2, 3'd5, 5'd1, 7'h13), 0,
                  32'h80000000, 32'h55,
                  32'h80000000, 4, 4'b0110, 0, 0);
    vecs[2]  = mk(enc(7'h00, 5'd9, 5'd3, 3'd6, 5'd0, 7'h63), 0, 3, 9,
                  3, 9, 4'b1000, 1, 0);
    vecs[3]  = mk({20'h12345, 5'd5, 7'h37}, 0, 32'hdead, 1,
                  0, 32'h12345000, 4'b0000, 0, 0);
    vecs[4]  = mk({20'h00001, 5'd4, 7'h17}, 32'h100, 9, 9,
                  32'h100, 32'h1000, 4'b0000, 0, 0);
    vecs[5]  = mk(enc(7'h20, 5'd1, 5'd1, 3'd0, 5'd2, 7'h7f), 0,
                  32'h11, 32'h22, 0, 0, 4'b0000, 0, ILL);
    vecs[6]  = mk(enc(7'h20, 5'd3, 5'd1, 3'd0, 5'd4, 7'h33), 0, 10, 3,
                  10, 3, 4'b0001, 0, 0);
    vecs[7]  = mk(enc_i(12'hfff, 5'd1, 3'd0, 5'd6, 7'h13), 0, 20, 1,
                  20, 32'hffffffff, 4'b0000, 0, 0);
    vecs[8]  = mk(enc(7'h7f, 5'd2, 5'd1, 3'd2, 5'h18, 7'h23), 0,
                  32'h1000, 5, 32'h1000, 32'hfffffff8, 4'b0000, 0, 0);
    vecs[9]  = mk(enc_i(12'd16, 5'd1, 3'd2, 5'd7, 7'h03), 0,
                  32'h200, 1, 32'h200, 16, 4'b0000, 0, 0);
    vecs[10] = mk(enc(7'h00, 5'd2, 5'd1, 3'd3, 5'd8, 7'h33), 0, 1, 2,
                  1, 2, 4'b1000, 0, 0);
    vecs[11] = ILL ?
      mk(enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33), 0, 4, 6,
         0, 0, 4'b0000, 0, 1) :
      mk(enc(7'h01, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33), 0, 4, 6,
         4, 6, 4'b0000, 0, 0);
    vecs[12] = mk(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63), 0, 8, 8,
                  8, 8, 4'b0001, 1, 0);
    vecs[13] = mk(enc_i(12'h0f0, 5'd1, 3'd4, 5'd10, 7'h13), 0,
                  32'hff, 0, 32'hff, 32'hf0, 4'b0111, 0, 0);
    vecs[14] = mk(enc(7'h00, 5'd31, 5'd1, 3'd5, 5'd11, 7'h13), 0,
                  32'h80000000, 0, 32'h80000000, 31, 4'b0101, 0, 0);
    vecs[15] = mk(enc(7'h00, 5'd2, 5'd1, 3'd6, 5'd12, 7'h33), 0,
                  32'hf0, 32'h0f, 32'hf0, 32'h0f, 4'b0100, 0, 0);
    vecs[16] = mk(enc(7'h00, 5'd2, 5'd1, 3'd7, 5'd13, 7'h33), 0,
                  32'h3c, 32'h0f, 32'h3c, 32'h0f, 4'b0010, 0, 0);
    vecs[17] = mk(enc(7'h00, 5'd2, 5'd1, 3'd1, 5'd14, 7'h33), 0,
                  1, 4, 1, 4, 4'b0011, 0, 0);
    vecs[18] = ILL ?
      mk(enc(7'h20, 5'd3, 5'd1, 3'd1, 5'd15, 7'h13), 0, 1, 0,
         0, 0, 4'b0000, 0, 1) :
      mk(enc(7'h20, 5'd3, 5'd1, 3'd1, 5'd15, 7'h13), 0, 1, 0,
         1, 3, 4'b0011, 0, 0);

    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_pc       = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
    bus.out_ready   = 1'b0;
    last_rdy        = 1'b0;

    repeat (3) @(negedge clk);
    check_bit("rst_in_ready", bus.in_ready, 1'b0);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_data", got(), '0);
    reset = 1'b0;
    #1;
    check_bit("rel_in_ready", bus.in_ready, 1'b1);

    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.in_instr    = vecs[k].instr;
      bus.in_pc       = vecs[k].pc;
      bus.in_rs1_data = vecs[k].rs1;
      bus.in_rs2_data = vecs[k].rs2;
      bus.out_ready   = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_bit($sformatf("vec%0d_valid", k), bus.out_valid, 1'b1);
      check($sformatf("vec%0d", k), got(), vecs[k].e);
    end

    // Backpressure: three stalled cycles mid-stream
    step(1, enc_i(12'd1, 5'd1, 3'd0, 5'd1, 7'h13), 0, 100, 0, 1);
    step(1, enc_i(12'd2, 5'd1, 3'd0, 5'd2, 7'h13), 0, 200, 0, 0);
    check_bit("bp_rdy0", last_rdy, 1'b1);
    step(1, enc_i(12'd3, 5'd1, 3'd0, 5'd3, 7'h13), 0, 300, 0, 0);
    check_bit("bp_rdy1", last_rdy, 1'b0);
    step(1, enc_i(12'd3, 5'd1, 3'd0, 5'd3, 7'h13), 0, 300, 0, 0);
    check_bit("bp_rdy2", last_rdy, 1'b0);
    step(1, enc_i(12'd3, 5'd1, 3'd0, 5'd3, 7'h13), 0, 300, 0, 1);
    check_bit("bp_rdy3", last_rdy, 1'b0);
    step(1, enc_i(12'd3, 5'd1, 3'd0, 5'd3, 7'h13), 0, 300, 0, 1);
    check_bit("bp_rdy4", last_rdy, 1'b1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL bp_drain: got %0d pending, want 0", q.size());

    // Reset with skid full
    step(1, enc_i(12'd7, 5'd1, 3'd0, 5'd4, 7'h13), 0, 1, 0, 1);
    step(1, enc_i(12'd8, 5'd1, 3'd0, 5'd5, 7'h13), 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_bit("pre_rst_rdy", last_rdy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_bit("mid_rst_valid", bus.out_valid, 1'b0);
    check_bit("mid_rst_rdy", bus.in_ready, 1'b0);
    q.delete();
    reset = 1'b0;
    #1;
    check_bit("post_rst_rdy", bus.in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 1);
      check_bit($sformatf("no_stale%0d", k), bus.out_valid, 1'b0);
    end

    // Random stream against the reference model
    pv = 1'b0;
    pi = '0;
    ppc = '0;
    pa = '0;
    pb = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!pv) begin
        pv  = ($urandom_range(0, 3) != 0);
        pi  = rand_instr();
        ppc = $urandom;
        pa  = $urandom;
        pb  = $urandom;
      end
      step(pv, pi, ppc, pa, pb, ($urandom_range(0, 9) < 7));
      if (pv && last_rdy) pv = 1'b0;
    end
    for (int c = 0; c < 20 && q.size() > 0; c++)
      step(0, 0, 0, 0, 0, 1);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL rand_drain: got %0d pending, want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
